// File: rtl/overvoltage_pkg.sv
// overvoltage_pkg: shared state type, trip-code width and default filter constants.
package overvoltage_pkg;

    localparam int OTRIP_W = 4;
    localparam int DEF_DEB_ASSERT = 4;
    localparam int DEF_DEB_DEASSERT = 16;
    localparam int DEF_BLANK_CYCLES = 16;
    localparam logic [OTRIP_W-1:0] DEF_OTRIP_RST = 4'hF;

    typedef enum logic [1:0] {DISABLED, BLANK, MONITOR, TRIPPED} ov_state_t;

endpackage

// File: rtl/overvoltage_filt_if.sv
// overvoltage_filt_if: control/status bundle between the host side and the overvoltage filter.
interface overvoltage_filt_if;
    import overvoltage_pkg::*;

    logic ena;
    logic ovout;
    logic [OTRIP_W-1:0] otrip_req;
    logic otrip_wr;
    logic irq_clr;
    logic [OTRIP_W-1:0] otrip;
    logic busy;
    logic ov_flag;
    logic ov_sticky;
    logic irq;

    modport master (
        output ena, ovout, otrip_req, otrip_wr, irq_clr,
        input  otrip, busy, ov_flag, ov_sticky, irq
    );

    modport slave (
        input  ena, ovout, otrip_req, otrip_wr, irq_clr,
        output otrip, busy, ov_flag, ov_sticky, irq
    );

endinterface

// File: rtl/overvoltage_sync.sv
// overvoltage_sync: STAGES-deep flop chain bringing the asynchronous comparator into clk.
module overvoltage_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) sr <= '0;
        else     sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/overvoltage_filt.sv
// overvoltage_filt: trip-code register, blanking and asymmetric debounce of the comparator.
// Define OVERVOLTAGE_FALL_IRQ_EN to also raise irq on a debounced ov_flag fall.
module overvoltage_filt
    import overvoltage_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W = 8,
    parameter int DEB_ASSERT = DEF_DEB_ASSERT,
    parameter int DEB_DEASSERT = DEF_DEB_DEASSERT,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter logic [OTRIP_W-1:0] OTRIP_RST = DEF_OTRIP_RST
) (
    input logic clk,
    input logic rst,
    overvoltage_filt_if.slave bus
);

    localparam logic [DEB_W-1:0] A_TH = DEB_W'(DEB_ASSERT);
    localparam logic [DEB_W-1:0] D_TH = DEB_W'(DEB_DEASSERT);
    localparam logic [DEB_W-1:0] B_TH = DEB_W'(BLANK_CYCLES);

    logic s;
    ov_state_t state, state_n;
    logic [DEB_W-1:0] dcnt, dcnt_n, bcnt, bcnt_n, dinc;
    logic [OTRIP_W-1:0] otrip, otrip_n;
    logic flag, flag_n, sticky, sticky_n, irq_r, irq_n, irq_set;

    overvoltage_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.ovout),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DISABLED;
            dcnt   <= '0;
            bcnt   <= '0;
            otrip  <= OTRIP_RST;
            flag   <= 1'b0;
            sticky <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            state  <= state_n;
            dcnt   <= dcnt_n;
            bcnt   <= bcnt_n;
            otrip  <= otrip_n;
            flag   <= flag_n;
            sticky <= sticky_n;
            irq_r  <= irq_n;
        end
    end

    assign dinc = (dcnt == '1) ? dcnt : dcnt + DEB_W'(1);

    // Thresholds are checked on the registered count, so a transition lands one edge after the last qualifying sample.
    always_comb begin
        state_n  = state;
        dcnt_n   = dcnt;
        bcnt_n   = bcnt;
        flag_n   = flag;
        sticky_n = sticky;
        irq_set  = 1'b0;
        otrip_n  = bus.otrip_wr ? bus.otrip_req : otrip;
        if (!bus.ena) begin
            state_n = DISABLED;
            dcnt_n  = '0;
            bcnt_n  = '0;
            flag_n  = 1'b0;
        end else if (bus.otrip_wr || state == DISABLED) begin
            state_n = BLANK;
            dcnt_n  = '0;
            bcnt_n  = '0;
        end else if (state == BLANK) begin
            bcnt_n = bcnt + DEB_W'(1);
            if (bcnt_n == B_TH) begin
                state_n = flag ? TRIPPED : MONITOR;
                bcnt_n  = '0;
            end
        end else if (state == MONITOR) begin
            if (dcnt >= A_TH) begin
                state_n  = TRIPPED;
                dcnt_n   = '0;
                flag_n   = 1'b1;
                sticky_n = 1'b1;
                irq_set  = 1'b1;
            end else begin
                dcnt_n = s ? dinc : '0;
            end
        end else begin
            if (dcnt >= D_TH) begin
                state_n = MONITOR;
                dcnt_n  = '0;
                flag_n  = 1'b0;
`ifdef OVERVOLTAGE_FALL_IRQ_EN
                irq_set = 1'b1;
`else
                irq_set = 1'b0;
`endif
            end else begin
                dcnt_n = s ? '0 : dinc;
            end
        end
        irq_n = irq_set | (irq_r & ~bus.irq_clr);
    end

    assign bus.otrip     = otrip;
    assign bus.busy      = (state == BLANK);
    assign bus.ov_flag   = flag;
    assign bus.ov_sticky = sticky;
    assign bus.irq       = irq_r;

endmodule

// File: doc/overvoltage_filt.md
# overvoltage_filt

Digital back end of the overvoltage detector. It owns the 4-bit trip code that drives the trip-voltage 4-to-16 decoder, and it consumes the asynchronous comparator output `ovout`. The comparator output passes through a synchronizer, a blanking interval that allows the ladder to settle after a code change, and an asymmetric debounce filter. The result is a filtered overvoltage level, a sticky status bit and an interrupt.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `ovout`; minimum 2.
- `DEB_W`, 8: width of the debounce and blank counters.
- `DEB_ASSERT`, 4: consecutive high samples required to assert `ov_flag`; range 1..2^DEB_W-1.
- `DEB_DEASSERT`, 16: consecutive low samples required to deassert `ov_flag`; range 1..2^DEB_W-1.
- `BLANK_CYCLES`, 16: settling cycles after a code change or enable; range 1..2^DEB_W-1.
- `OTRIP_RST`, 4'hF: trip code loaded at reset (highest threshold).
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `ena` input 1: detector enable, level.
- `ovout` input 1: comparator output; asynchronous to `clk`.
- `otrip_req` input 4: requested trip code.
- `otrip_wr` input 1: one-cycle strobe that loads `otrip_req`.
- `irq_clr` input 1: one-cycle strobe that clears `irq`.
- `otrip` output 4: applied trip code, feeding the decoder.
- `busy` output 1: high while blanking.
- `ov_flag` output 1: filtered overvoltage level.
- `ov_sticky` output 1: set when `ov_flag` rises; cleared only by `rst`.
- `irq` output 1: interrupt, a level held until cleared.

## Operation
- Reset values: `otrip`=OTRIP_RST; `busy`, `ov_flag`, `ov_sticky`, `irq` all 0; state DISABLED; all counters 0.
- FSM states: DISABLED, BLANK, MONITOR, TRIPPED.
- DISABLED:
  - `ov_flag`=0 and counters are held at 0.
  - `ena`=1 → BLANK.
- BLANK:
  - `busy`=1 and synchronized samples are ignored.
  - The blank counter runs to BLANK_CYCLES.
  - `ov_flag` holds its previous value.
  - On expiry → TRIPPED if `ov_flag`=1, else MONITOR.
- MONITOR:
  - The count increments on each high sample and resets to 0 on a low sample.
  - When it reaches DEB_ASSERT → TRIPPED, with `ov_flag`←1, `ov_sticky`←1, `irq`←1.
- TRIPPED:
  - The count increments on each low sample and resets on a high sample.
  - When it reaches DEB_DEASSERT → MONITOR, with `ov_flag`←0.
- Trip-code load:
  - `otrip_wr`=1 always loads `otrip`←`otrip_req`, in any state.
  - If `ena`=1, the block enters BLANK with the blank and debounce counters cleared. A write during BLANK restarts blanking.
- `ena`=0 in any state:
  - → DISABLED on the next edge, with `ov_flag`←0.
  - `ov_sticky` and `irq` are untouched.
  - If `ena`=0 and `otrip_wr`=1 arrive together, the code loads and the state is DISABLED.
- `irq`:
  - Cleared by `irq_clr`.
  - If a set event and `irq_clr` occur in the same cycle, the set wins.
- Counters saturate and never wrap.

## Timing
- All outputs are registered.
- Synchronizer: `ovout` is visible to the filter after SYNC_STAGES edges.
- Assertion latency: `ovout` high and stable before edge 0 → `ov_flag` and `irq` high after edge SYNC_STAGES+DEB_ASSERT (6 with defaults).
- Deassertion latency: `ov_flag` falls after edge SYNC_STAGES+DEB_DEASSERT of stable low.
- Write strobe: `otrip_wr` sampled at edge 0 → `otrip` and `busy` change after edge 0. `busy` falls after edge BLANK_CYCLES, and samples are counted from edge BLANK_CYCLES+1.
- `ena` rise at edge 0 → `busy` high after edge 0, with the same blank timing as a write.
- `rst` overrides every other input in the same edge.

## Configuration
- `OVERVOLTAGE_FALL_IRQ_EN` defined:
  - `irq` is also set on the `ov_flag` 1→0 transition from TRIPPED.
  - The forced deassertion caused by `ena` falling does not set `irq`.
- Macro undefined: `irq` is set only on `ov_flag` rising.

## Structure
- Package `overvoltage_pkg`:
  - FSM state enum `ov_state_t`.
  - Default constants for `DEB_ASSERT`, `DEB_DEASSERT`, `BLANK_CYCLES` and `OTRIP_RST`.
  - `localparam` for the trip-code width (4).
- Sub-module `overvoltage_sync`:
  - A parameterized SYNC_STAGES flop chain with synchronous reset to 0.
  - Its output feeds the FSM.

## Test plan
- Reset with defaults → `otrip`=4'hF and all flags 0. Write `otrip_req`=4'h3 with `ena`=0 → `otrip`=3 next cycle, `busy` stays 0.
- `ena`↑ then `ovout`=1 applied after `busy` falls → `ov_flag`, `ov_sticky` and `irq` rise exactly 6 edges after `ovout` high. A pulse of 3 high cycles → `ov_flag` stays 0.
- While TRIPPED: `ovout` low for 15 cycles, then 1 high, then 16 low → `ov_flag` falls only after the final 16-cycle run, and `ov_sticky` remains 1.
- `otrip_wr` during MONITOR with `ovout`=1 → `busy` is high for 16 cycles and `ov_flag` stays 0 during it. A second `otrip_wr` at blank cycle 10 extends `busy` to 16 cycles from that write.
- `irq_clr` asserted in the same cycle as an `ov_flag` rise → `irq`=1. `irq_clr` alone a cycle later → `irq`=0.
- `ena`↓ while TRIPPED → `ov_flag`=0 next cycle, and `irq` is not re-set when built with `OVERVOLTAGE_FALL_IRQ_EN`. A normal debounced fall with the macro defined → `irq`=1.
